// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default timing
// constants and a small helper for sizing the shared cycle counter.
package pll_seq_pkg;

  // Encoding is visible on the state output, so values are pinned explicitly.
  typedef enum logic [2:0] {
    StRstPll   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } pll_seq_state_e;

  // Defaults assume a 27 MHz crystal clock.
  localparam int unsigned DefRstCycles   = 27;     // 1 us PLL reset pulse
  localparam int unsigned DefLockTimeout = 27000;  // 1 ms per lock attempt
  localparam int unsigned DefLockStable  = 270;    // 10 us of steady lock
  localparam int unsigned DefMaxRetries  = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture the async input, then resolve metastability in the second stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL RESET, waits for lock, demands a stable lock
// window, then releases the PLL-domain reset. Retries a bounded number of times
// before parking in FAULT until restart or rst_n.
// Optional build macro PLL_SEQ_LOSS_CNT_EN adds a saturating count of lock losses
// seen while running (loss_cnt output).
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = DefRstCycles,
  parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
  parameter int unsigned LOCK_STABLE  = DefLockStable,
  parameter int unsigned MAX_RETRIES  = DefMaxRetries
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  // One counter serves every timed state; the extra bit keeps it from wrapping.
  localparam int unsigned CntMax = max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic [CntW-1:0] RstLast  = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] ToLast   = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StbLast  = CntW'(LOCK_STABLE - 1);
  localparam logic [3:0]      MaxRetry = 4'(MAX_RETRIES);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  pll_seq_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic            pll_reset_q, pll_reset_d;
  logic            sys_rst_n_q, sys_rst_n_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;
  logic            fail;

  // Next-state, counter, retry bookkeeping and output decode from the next state,
  // so registered outputs change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail    = 1'b0;

    if (restart) begin
      // Also covers restart while already in RST_PLL: the pulse count starts over.
      state_d = StRstPll;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StRstPll: begin
          if (cnt_q == RstLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == ToLast) begin
            fail = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StStable: begin
          if (!lock_s) begin
            fail = 1'b1;
          end else if (cnt_q == StbLast) begin
            state_d = StRun;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          // Loss of lock while running is not a failed attempt.
          if (!lock_s) begin
            state_d = StRstPll;
            cnt_d   = '0;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StRstPll;
          cnt_d   = '0;
        end
      endcase

      if (fail) begin
        retry_d = retry_q + 4'd1;
        cnt_d   = '0;
        state_d = (retry_d == MaxRetry) ? StFault : StRstPll;
      end
    end

    pll_reset_d = (state_d == StRstPll) || (state_d == StFault);
    sys_rst_n_d = (state_d == StRun);
    ready_d     = (state_d == StRun);
    fault_d     = (state_d == StFault);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRstPll;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic       lock_lost;
  logic [7:0] loss_q;

  assign lock_lost = (state_q == StRun) && !lock_s && !restart;

  // Saturating count of RUN-to-RST_PLL lock losses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= 8'd0;
    end else if (restart) begin
      loss_q <= 8'd0;
    end else if (lock_lost && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
`else
  // Loss counter not built.
`endif

endmodule
